// File: rtl/lfsr_countdown_multi.sv
// Multi-channel Galois LFSR countdown timer with one-shot/periodic modes,
// pause, abort, and sticky expiry flag with overrun detection.
module lfsr_countdown_multi #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned WIDTH = 35,
   parameter logic [WIDTH-1:0] POLY = 35'h500000000,
   parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter logic [CHANNELS*WIDTH-1:0] STOP =
      {CHANNELS{35'h0b7b32de0}},
   parameter logic [CHANNELS-1:0] PERIODIC = '0
) (
   input  logic                clock,
   input  logic                i_reset_n,
   input  logic [CHANNELS-1:0] i_start,
   input  logic [CHANNELS-1:0] i_stop,
   input  logic [CHANNELS-1:0] i_enable,
   input  logic [CHANNELS-1:0] i_ack,
   output logic [CHANNELS-1:0] o_busy,
   output logic [CHANNELS-1:0] o_done,
   output logic [CHANNELS-1:0] o_flag,
   output logic [CHANNELS-1:0] o_overrun
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      localparam logic [WIDTH-1:0] STOP_C = STOP[c*WIDTH +: WIDTH];

      state_t           state_q, state_d;
      logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nx;
      logic             done_q, done_d;
      logic             flag_q, flag_d;
      logic             ovr_q, ovr_d;
      logic             step, expire;

      assign lfsr_nx = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
      assign step    = (state_q == RUN) && i_enable[c]
                       && !i_start[c] && !i_stop[c];
      // Compare on the next state so o_done lands on the counting edge
      assign expire  = step && (lfsr_nx == STOP_C);

      always_comb begin
         state_d = state_q;
         lfsr_d  = lfsr_q;
         done_d  = expire;
         flag_d  = flag_q;
         ovr_d   = ovr_q;
         if (i_start[c]) begin
            state_d = RUN;
            lfsr_d  = SEED;
         end else if (i_stop[c]) begin
            state_d = IDLE;
            lfsr_d  = SEED;
         end else if (expire) begin
            state_d = PERIODIC[c] ? RUN : IDLE;
            lfsr_d  = SEED;
         end else if (step) begin
            lfsr_d = lfsr_nx;
         end
         if (expire) begin
            flag_d = 1'b1;
            if (flag_q && !i_ack[c]) ovr_d = 1'b1;
            else if (i_ack[c]) ovr_d = 1'b0;
         end else if (i_ack[c]) begin
            flag_d = 1'b0;
            ovr_d  = 1'b0;
         end
      end

      always_ff @(posedge clock or negedge i_reset_n) begin
         if (!i_reset_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            done_q  <= 1'b0;
            flag_q  <= 1'b0;
            ovr_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            done_q  <= done_d;
            flag_q  <= flag_d;
            ovr_q   <= ovr_d;
         end
      end

      assign o_busy[c]    = (state_q == RUN);
      assign o_done[c]    = done_q;
      assign o_flag[c]    = flag_q;
      assign o_overrun[c] = ovr_q;
   end

endmodule
